// File: rtl/sa_tile_controller.sv
// sa_tile_controller
//   Multi-tile sequencer for the systolic-array matrix unit. One start pulse
//   runs a job of num_tiles tiles: per tile it waits for both input buffers,
//   times the CAL-cycle compute window, and after every accumulation group
//   (or the final partial group) drains SA_ROWS result rows to the output
//   buffer, stalling while that buffer is not empty.
//
// Ports
//   i_clk, i_rst_n            clock, async active-low reset
//   i_start                   job start (sampled in S_IDLE only)
//   i_num_tiles, i_acc_depth  job fields, latched on accepted start
//   i_abort                   synchronous job abort
//   i_ibh/ibv_data_in_done    input buffers loaded
//   i_ob_empty                output buffer can take a drain
//   o_ib_data_out, o_sa_clear tile launch pulses (combinational)
//   o_sa_send_data, o_ob_data_in  drain window
//   o_busy, o_done            job status
//   o_stall_cycles            saturating S_STALL cycle count for the job
module sa_tile_controller #(
  parameter int INA_ROWS = 3,
  parameter int INA_COLS = 9,
  parameter int SA_ROWS  = 3,
  parameter int SA_COLS  = 1,
  parameter int TILE_W   = 8,
  parameter int STALL_W  = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [TILE_W-1:0]  i_num_tiles,
  input  logic [TILE_W-1:0]  i_acc_depth,
  input  logic               i_abort,
  input  logic               i_ibh_data_in_done,
  input  logic               i_ibv_data_in_done,
  input  logic               i_ob_empty,
  output logic               o_ib_data_out,
  output logic               o_sa_clear,
  output logic               o_sa_send_data,
  output logic               o_ob_data_in,
  output logic               o_busy,
  output logic               o_done,
  output logic [STALL_W-1:0] o_stall_cycles
);

  localparam int CAL     = INA_COLS + INA_ROWS + SA_COLS - 1;
  localparam int CYC_MAX = (CAL > SA_ROWS) ? CAL : SA_ROWS;
  localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
  localparam logic [CYC_W-1:0] CAL_LAST = CYC_W'(CAL - 1);
  localparam logic [CYC_W-1:0] OUT_LAST = CYC_W'(SA_ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_IN, S_COMPUTE, S_STALL, S_OUTPUT, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [TILE_W-1:0]  num_q, acc_q;
  logic [TILE_W-1:0]  tile_q, tile_d, grp_q, grp_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               bufs_rdy, last_tile, grp_end, accept;

  assign bufs_rdy  = i_ibh_data_in_done && i_ibv_data_in_done;
  assign last_tile = (tile_q == num_q - TILE_W'(1));
  // The final tile always closes its group so a partial group still drains.
  assign grp_end   = (grp_q == acc_q - TILE_W'(1)) || last_tile;
  assign accept    = (state_q == S_IDLE) && i_start;

  always_comb begin
    state_d       = state_q;
    tile_d        = tile_q;
    grp_d         = grp_q;
    cyc_d         = cyc_q;
    stall_d       = stall_q;
    o_ib_data_out = 1'b0;
    o_sa_clear    = 1'b0;
    case (state_q)
      S_IDLE: if (i_start) begin
        tile_d  = '0;
        grp_d   = '0;
        cyc_d   = '0;
        stall_d = '0;
        state_d = (i_num_tiles == '0) ? S_DONE : S_WAIT_IN;
      end
      S_WAIT_IN: if (bufs_rdy) begin
        o_ib_data_out = 1'b1;
        o_sa_clear    = (grp_q == '0);
        cyc_d         = '0;
        state_d       = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (cyc_q == CAL_LAST) begin
          cyc_d = '0;
          if (grp_end) begin
            state_d = i_ob_empty ? S_OUTPUT : S_STALL;
          end else begin
            grp_d   = grp_q + TILE_W'(1);
            tile_d  = tile_q + TILE_W'(1);
            state_d = S_WAIT_IN;
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      S_STALL: begin
        if (stall_q != '1) stall_d = stall_q + STALL_W'(1);
        if (i_ob_empty) begin
          cyc_d   = '0;
          state_d = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (cyc_q == OUT_LAST) begin
          cyc_d = '0;
          grp_d = '0;
          if (last_tile) begin
            state_d = S_DONE;
          end else begin
            tile_d  = tile_q + TILE_W'(1);
            state_d = S_WAIT_IN;
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort wins over everything; no tile is launched on the abort cycle and
    // the stall count is frozen for inspection.
    if (i_abort && state_q != S_IDLE) begin
      state_d       = S_IDLE;
      stall_d       = stall_q;
      o_ib_data_out = 1'b0;
      o_sa_clear    = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      num_q   <= '0;
      acc_q   <= '0;
      tile_q  <= '0;
      grp_q   <= '0;
      cyc_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      tile_q  <= tile_d;
      grp_q   <= grp_d;
      cyc_q   <= cyc_d;
      stall_q <= stall_d;
      if (accept) begin
        num_q <= i_num_tiles;
        acc_q <= (i_acc_depth == '0) ? TILE_W'(1) : i_acc_depth;
      end
    end
  end

  assign o_busy         = (state_q != S_IDLE);
  assign o_sa_send_data = (state_q == S_OUTPUT);
  assign o_ob_data_in   = (state_q == S_OUTPUT);
  assign o_done         = (state_q == S_DONE);
  assign o_stall_cycles = stall_q;

endmodule

// File: tb/tb_sa_tile_controller.sv
// Scoreboard bench for sa_tile_controller. Each job pushes its expected
// event timeline (kind*1000 + cycle relative to the start cycle); a negedge
// monitor pops one entry per observed output event and compares.
module tb_sa_tile_controller;
  localparam int CAL     = 12;
  localparam int SA_ROWS = 3;
  localparam int EV_IB = 1, EV_CLR = 2, EV_SEND = 3, EV_DONE = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_start, i_abort;
  logic [7:0]  i_num_tiles, i_acc_depth;
  logic        i_ibh_data_in_done, i_ibv_data_in_done, i_ob_empty;
  logic        o_ib_data_out, o_sa_clear, o_sa_send_data, o_ob_data_in;
  logic        o_busy, o_done;
  logic [15:0] o_stall_cycles;

  int errors = 0, checks = 0;
  int cyc = 0, t0 = 0;
  bit sb_on = 1'b0;
  int sb_q[$];
  int lim;

  sa_tile_controller dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .i_num_tiles(i_num_tiles), .i_acc_depth(i_acc_depth), .i_abort(i_abort),
    .i_ibh_data_in_done(i_ibh_data_in_done), .i_ibv_data_in_done(i_ibv_data_in_done),
    .i_ob_empty(i_ob_empty), .o_ib_data_out(o_ib_data_out), .o_sa_clear(o_sa_clear),
    .o_sa_send_data(o_sa_send_data), .o_ob_data_in(o_ob_data_in),
    .o_busy(o_busy), .o_done(o_done), .o_stall_cycles(o_stall_cycles)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input string tag, input int obs);
    if (sb_q.size() == 0) chk(tag, obs, -1);
    else chk(tag, obs, sb_q.pop_front());
  endtask

  function automatic void push(input int kind, input int c);
    if (c < lim) sb_q.push_back(kind * 1000 + c);
  endfunction

  always @(negedge i_clk) begin
    int rel;
    rel = cyc - t0;
    if (sb_on) begin
      if (o_ib_data_out) sb_pop("ib", EV_IB * 1000 + rel);
      if (o_sa_clear) sb_pop("clr", EV_CLR * 1000 + rel);
      if (o_sa_send_data) sb_pop("send", EV_SEND * 1000 + rel);
      if (o_ob_data_in != o_sa_send_data) chk("ob_in", o_ob_data_in, o_sa_send_data);
      if (o_done) sb_pop("done", EV_DONE * 1000 + rel);
    end
  end

  // Runs one job. ibv rises at ib_rise, ob_empty rises at ob_rise (both held
  // high after), abort pulses at abort_at (<0: none), poke re-asserts start.
  task automatic run_job(input int num, input int acc, input int ib_rise,
                         input int ob_rise, input int abort_at, input bit poke);
    int t, end_c, o, grp, acc_e, stall, done_c, end_rel;
    lim   = (abort_at < 0) ? 32'h7fff_ffff : abort_at;
    acc_e = (acc == 0) ? 1 : acc;
    t = 1; grp = 0; stall = 0;
    for (int k = 0; k < num; k++) begin
      if (t < ib_rise) t = ib_rise;
      push(EV_IB, t);
      if (grp == 0) push(EV_CLR, t);
      end_c = t + CAL;
      if (grp == acc_e - 1 || k == num - 1) begin
        if (end_c >= ob_rise) o = end_c + 1;
        else begin o = ob_rise + 1; stall += ob_rise - end_c; end
        for (int j = 0; j < SA_ROWS; j++) push(EV_SEND, o + j);
        t = o + SA_ROWS; grp = 0;
      end else begin
        t = end_c + 1; grp++;
      end
    end
    done_c = t;
    push(EV_DONE, done_c);
    end_rel = (abort_at < 0) ? done_c + 1 : abort_at + 1;

    @(posedge i_clk); #1;
    t0 = cyc; sb_on = 1'b1;
    i_start = 1'b1; i_num_tiles = 8'(num); i_acc_depth = 8'(acc);
    for (int r = 0; r <= end_rel; r++) begin
      if (r > 0) begin
        @(posedge i_clk); #1;
        i_start = poke && (r == 5);
        i_num_tiles = 8'hff; i_acc_depth = 8'h03;
      end
      i_ibh_data_in_done = 1'b1;
      i_ibv_data_in_done = (r >= ib_rise);
      i_ob_empty = (r >= ob_rise);
      i_abort = (r == abort_at);
      if (r == 1) chk("busy_start", o_busy, 1);
    end
    chk("busy_end", o_busy, 0);
    chk("stall_cnt", o_stall_cycles, stall);
    chk("sb_left", sb_q.size(), 0);
    sb_q.delete();
    i_abort = 1'b0;
  endtask

  initial begin
    i_rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0;
    i_num_tiles = '0; i_acc_depth = '0;
    i_ibh_data_in_done = 1'b0; i_ibv_data_in_done = 1'b0; i_ob_empty = 1'b0;
    repeat (3) @(posedge i_clk); #1;
    chk("rst_outs", {o_ib_data_out, o_sa_clear, o_sa_send_data, o_ob_data_in, o_busy, o_done}, 0);
    chk("rst_stall", o_stall_cycles, 0);
    i_rst_n = 1'b1;

    run_job(1, 1, 0, 0, -1, 1'b1);   // single tile, start re-poked mid-job
    run_job(4, 2, 0, 0, -1, 1'b0);   // two full groups
    run_job(3, 2, 0, 0, -1, 1'b0);   // forced flush of partial group
    run_job(1, 1, 0, 20, -1, 1'b0);  // output-buffer stall 14..20
    run_job(0, 1, 0, 0, -1, 1'b0);   // empty job
    run_job(1, 1, 0, 0, 8, 1'b0);    // abort mid-compute
    run_job(2, 0, 0, 0, -1, 1'b0);   // acc_depth 0 behaves as 1
    run_job(3, 3, 4, 0, -1, 1'b1);   // late vertical buffer, one group

    // Async reset in the middle of the output burst.
    sb_on = 1'b0;
    @(posedge i_clk); #1;
    t0 = cyc;
    i_start = 1'b1; i_num_tiles = 8'd1; i_acc_depth = 8'd1;
    i_ibh_data_in_done = 1'b1; i_ibv_data_in_done = 1'b1; i_ob_empty = 1'b1;
    for (int r = 1; r <= 15; r++) begin
      @(posedge i_clk); #1;
      i_start = 1'b0;
    end
    chk("pre_rst_send", o_sa_send_data, 1);
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {o_ib_data_out, o_sa_clear, o_sa_send_data, o_ob_data_in, o_busy, o_done}, 0);
    chk("mid_rst_stall", o_stall_cycles, 0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    repeat (2) @(posedge i_clk); #1;
    chk("post_rst_busy", o_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sa_tile_controller.md
# sa_tile_controller

Multi-tile sequencer for the systolic-array matrix unit. It runs a job of N tiles from a single start pulse. For each tile it waits on the input buffers and times the array compute window. It can accumulate a configurable number of tiles in the array before draining one result to the output buffer, and it stalls when that buffer is not empty. It also reports job completion and stall statistics, and sits between the host command interface and the input-buffer / array / output-buffer datapath.

## Interface
- INA_ROWS, 3, rows of the horizontal input tile
- INA_COLS, 9, columns of the input tile
- SA_ROWS, 3, array rows; output drain length in cycles
- SA_COLS, 1, array columns
- TILE_W, 8, width of the tile-count and accumulation-depth fields
- STALL_W, 16, width of the stall-cycle counter
- i_clk  in  1  clock; single clock domain
- i_rst_n  in  1  asynchronous, active-low reset
- i_start  in  1  job start; sampled in S_IDLE only
- i_num_tiles  in  TILE_W  tiles in the job; latched on accepted start
- i_acc_depth  in  TILE_W  tiles per accumulation group; latched on start; 0 is treated as 1
- i_abort  in  1  synchronous job abort
- i_ibh_data_in_done  in  1  horizontal input buffer loaded
- i_ibv_data_in_done  in  1  vertical input buffer loaded
- i_ob_empty  in  1  output buffer can accept a drain
- o_ib_data_out  out  1  one-cycle pulse: input buffers start streaming
- o_sa_clear  out  1  one-cycle pulse with o_ib_data_out on the first tile of a group; array clears its accumulators
- o_sa_send_data  out  1  array shifts results out
- o_ob_data_in  out  1  output buffer captures data (identical to o_sa_send_data)
- o_busy  out  1  high whenever state is not S_IDLE
- o_done  out  1  one-cycle job-complete pulse
- o_stall_cycles  out  STALL_W  saturating count of S_STALL cycles in the current/last job

## Operation
- CAL = INA_COLS+INA_ROWS+SA_COLS-1 compute cycles per tile (12 at default parameters).
- Internal counters:
  - tile_cnt counts 0..num_tiles-1.
  - grp_cnt counts 0..acc_depth-1.
  - cyc_cnt is sized for max(CAL, SA_ROWS).
- States:
  - S_IDLE: on i_start, latch the fields, clear the counters and o_stall_cycles. If num_tiles==0, go to S_DONE; otherwise go to S_WAIT_IN.
  - S_WAIT_IN: when both done inputs are high in the same cycle, assert o_ib_data_out that cycle (Mealy). Also assert o_sa_clear if grp_cnt==0. Go to S_COMPUTE.
  - S_COMPUTE: stay exactly CAL cycles. On the last cycle the tile is a group end if grp_cnt==acc_depth-1 OR tile_cnt==num_tiles-1 (forced flush of a partial final group).
    - Group end with i_ob_empty: go to S_OUTPUT.
    - Group end with !i_ob_empty: go to S_STALL.
    - Not a group end: increment grp_cnt and tile_cnt, go to S_WAIT_IN.
  - S_STALL: increment o_stall_cycles each cycle, saturating at all-ones. Go to S_OUTPUT the cycle after i_ob_empty is seen high.
  - S_OUTPUT: stay exactly SA_ROWS cycles with o_sa_send_data=o_ob_data_in=1. On the last cycle, grp_cnt goes to 0.
    - If this was the last tile, go to S_DONE.
    - Otherwise increment tile_cnt and go to S_WAIT_IN.
  - S_DONE: o_done=1 for one cycle, then go to S_IDLE.
- i_abort in any non-idle state: next state is S_IDLE. No o_done is produced. Outputs deassert next cycle. o_stall_cycles holds its value.
- i_start outside S_IDLE is ignored. Input field changes after latch are ignored.
- Reset: state S_IDLE, all counters 0, every output 0, taking effect immediately on i_rst_n low, including mid-job.

## Timing
- Start accepted at cycle t gives S_WAIT_IN at t+1, with o_busy high from t+1.
- Buffers ready at cycle c gives o_ib_data_out at c, S_COMPUTE over c+1..c+CAL, and S_OUTPUT from c+CAL+1 if the buffer is empty.
- i_ob_empty rising at cycle s while in S_STALL gives S_OUTPUT from s+1.
- The last output cycle is followed by S_WAIT_IN at the next cycle. No idle gap is inserted between tiles.
- o_done occurs 1 cycle after the final output cycle. o_busy falls the cycle after o_done.
- Only registered state drives outputs, except o_ib_data_out and o_sa_clear, which are combinational from state and the done inputs.

## Test plan
- num_tiles=1, acc=1, all readies high, start at cycle 0 -> o_ib_data_out and o_sa_clear at cycle 1, S_COMPUTE 2..13, send/ob_in high 14..16, o_done at 17, o_busy low at 18.
- num_tiles=4, acc=2 -> o_ib_data_out 4 pulses, o_sa_clear pulses on tiles 0 and 2 only, exactly 2 output bursts of 3 cycles, one o_done.
- num_tiles=3, acc=2 -> 2 bursts: after tile 1, and a forced flush after tile 2. grp_cnt is 0 at o_done.
- Single tile, i_ob_empty low until cycle 20 -> S_STALL 14..20, outputs 21..23, o_stall_cycles=7, o_done at 24.
- num_tiles=0 -> o_done at cycle 1, no o_ib_data_out / o_sa_clear / send. Start asserted during a running job -> ignored.
- i_abort at cycle 8 (mid-compute) -> S_IDLE at 9, no output burst, no o_done. i_rst_n low mid-output -> all outputs 0 immediately, no clock edge needed.
